// File: rtl/alu_ctrl_pkg.sv
// Shared types for the EX-stage ALU control and the multiply/divide sequencer.
// Build option: ALU_CTRL_MDU_INTERLOCK_EN enables the HI/LO dependency stall.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [4:0] {
    ALU_AND  = 5'b00000,
    ALU_OR   = 5'b00001,
    ALU_ADD  = 5'b00010,
    ALU_XOR  = 5'b00011,
    ALU_ADDU = 5'b00100,
    ALU_SUBU = 5'b00101,
    ALU_SUB  = 5'b00110,
    ALU_SLT  = 5'b00111,
    ALU_SLTU = 5'b01000,
    ALU_SLL  = 5'b01001,
    ALU_SRL  = 5'b01010,
    ALU_SRA  = 5'b01011,
    ALU_NOR  = 5'b01100
  } alu_ctrl_e;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_WB   = 2'b10
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_hilo_dep(input logic [5:0] f);
    return is_mdu_op(f) || (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multiply/divide latency sequencer: tracks one in-flight HI/LO producer and
// pulses the HI/LO write in its final cycle.
module mdu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [1:0] op_i,
  output logic       start_o,
  output logic [1:0] op_o,
  output logic       busy_o,
  output logic       hilo_we_o
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             hilo_we_q, hilo_we_d;
  logic             start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      op_q      <= 2'b00;
      hilo_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hilo_we_q <= hilo_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_BUSY;
          // op bit 1 distinguishes the divide pair from the multiply pair
          cnt_d   = op_i[1] ? DIV_CNT : MUL_CNT;
          op_d    = op_i;
        end
      end
      MDU_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = MDU_WB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MDU_WB:  state_d = MDU_IDLE;
      default: state_d = MDU_IDLE;
    endcase
    hilo_we_d = (state_d == MDU_WB);
  end

  always_comb begin
    start     = req_i && (state_q == MDU_IDLE);
    start_o   = start;
    busy_o    = (state_q != MDU_IDLE);
    op_o      = op_q;
    hilo_we_o = hilo_we_q;
  end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decode with multiply/divide sequencing and HI/LO interlock.
// Build option: ALU_CTRL_MDU_INTERLOCK_EN enables stall_o; otherwise it is tied 0.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic       flush_i,
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_ctrl_o,
  output logic       illegal_o,
  output logic       mdu_start_o,
  output logic [1:0] mdu_op_o,
  output logic       mdu_busy_o,
  output logic       hilo_we_o,
  output logic       stall_o
);

  alu_ctrl_e ctrl_dec;
  logic      undecoded;
  logic      live;
  logic      mdu_req;

  always_comb begin
    ctrl_dec  = ALU_ADD;
    undecoded = 1'b0;
    case (alu_op_i)
      ALU_OP_ADD: ctrl_dec = ALU_ADD;
      ALU_OP_SUB: ctrl_dec = ALU_SUB;
      ALU_OP_OR:  ctrl_dec = ALU_OR;
      default: begin
        case (funct_i)
          F_ADD:  ctrl_dec = ALU_ADD;
          F_ADDU: ctrl_dec = ALU_ADDU;
          F_SUB:  ctrl_dec = ALU_SUB;
          F_SUBU: ctrl_dec = ALU_SUBU;
          F_AND:  ctrl_dec = ALU_AND;
          F_OR:   ctrl_dec = ALU_OR;
          F_XOR:  ctrl_dec = ALU_XOR;
          F_NOR:  ctrl_dec = ALU_NOR;
          F_SLT:  ctrl_dec = ALU_SLT;
          F_SLTU: ctrl_dec = ALU_SLTU;
          F_SLL:  ctrl_dec = ALU_SLL;
          F_SRL:  ctrl_dec = ALU_SRL;
          F_SRA:  ctrl_dec = ALU_SRA;
          // HI/LO movers and MDU ops do not consume the ALU result
          F_MFHI, F_MTHI, F_MFLO, F_MTLO,
          F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl_dec = ALU_ADD;
          default: begin
            ctrl_dec  = ALU_AND;
            undecoded = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    alu_ctrl_o = ctrl_dec;
    illegal_o  = valid_i && undecoded;
    live       = valid_i && !flush_i && (alu_op_i == ALU_OP_FUNCT);
    mdu_req    = live && is_mdu_op(funct_i);
  end

  mdu_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (mdu_req),
    .op_i      (funct_i[1:0]),
    .start_o   (mdu_start_o),
    .op_o      (mdu_op_o),
    .busy_o    (mdu_busy_o),
    .hilo_we_o (hilo_we_o)
  );

`ifdef ALU_CTRL_MDU_INTERLOCK_EN
  assign stall_o = live && is_hilo_dep(funct_i) && mdu_busy_o;
`else
  assign stall_o = 1'b0;
`endif

endmodule
